// File: rtl/fpu_pkg.sv
// fpu_pkg: shared rounding-mode encodings, float-to-int FSM states, saturation values and flag indices
package fpu_pkg;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam int BIAS = 127;
  localparam logic [31:0] SAT_W_POS  = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_W_NEG  = 32'h8000_0000;
  localparam logic [31:0] SAT_WU_POS = 32'hFFFF_FFFF;
  localparam logic [31:0] SAT_WU_NEG = 32'h0000_0000;
  localparam int FLAG_NX = 0;
  localparam int FLAG_NV = 1;
  typedef enum logic [1:0] {F2I_IDLE, F2I_ALIGN, F2I_ROUND, F2I_DONE} f2i_state_t;
  function automatic logic [31:0] f2i_sat(input logic uns, input logic neg);
    return uns ? (neg ? SAT_WU_NEG : SAT_WU_POS) : (neg ? SAT_W_NEG : SAT_W_POS);
  endfunction
endpackage

// File: rtl/fpu_f2i_round.sv
// fpu_f2i_round: rounds the aligned 32.32 fixed-point magnitude, range-checks it and saturates
module fpu_f2i_round
  import fpu_pkg::*;
(
  input  logic [63:0] i_r,
  input  logic        i_sign,
  input  logic [2:0]  i_rm,
  input  logic        i_uns,
  output logic [31:0] o_result,
  output logic [1:0]  o_flags
);
  logic        w_g, w_st, w_inc, w_nv;
  logic [32:0] w_mag;
  always_comb begin
    w_g = i_r[31];
    w_st = |i_r[30:0];
    w_inc = (i_rm == RM_RTZ) ? 1'b0 :
            (i_rm == RM_RDN) ? i_sign & (w_g | w_st) :
            (i_rm == RM_RUP) ? ~i_sign & (w_g | w_st) :
            (i_rm == RM_RMM) ? w_g : w_g & (w_st | i_r[32]);
    w_mag = {1'b0, i_r[63:32]} + {32'b0, w_inc};
    // -2^31 is the only magnitude above 2^31-1 a signed result can hold
    w_nv = i_uns ? (w_mag[32] | (i_sign & |w_mag)) :
           (w_mag > 33'h0_8000_0000) | ((w_mag == 33'h0_8000_0000) & ~i_sign);
    o_result = w_nv ? f2i_sat(i_uns, i_sign) : i_sign ? -w_mag[31:0] : w_mag[31:0];
    o_flags = '0;
    o_flags[FLAG_NV] = w_nv;
    o_flags[FLAG_NX] = (w_g | w_st) & ~w_nv;
  end
endmodule

// File: rtl/fpu_float_to_int.sv
// fpu_float_to_int: multi-cycle IEEE single to 32-bit int converter (FCVT.W.S/FCVT.WU.S)
// Define FPU_F2I_FASTZERO_EN to resolve |x|<1 without the iterative right shift.
module fpu_float_to_int
  import fpu_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand,
  input  logic        is_unsigned,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_nv,
  output logic        flag_nx
);
  localparam logic [5:0] S = 6'(SHIFT_PER_CYCLE);
  localparam logic signed [9:0] E_BIAS = 10'(BIAS);
  f2i_state_t r_state, w_next;
  logic [63:0] r_r, w_init_r, w_base_r, w_shl, w_shr;
  logic [5:0]  r_cnt, w_k, w_rcnt, w_init_cnt;
  logic        r_left, r_sign, r_uns, r_nv, r_nx;
  logic [2:0]  r_rm;
  logic [31:0] r_res, w_rnd_res;
  logic [1:0]  w_rnd_flags;
  logic [7:0]  w_exp;
  logic [22:0] w_mant;
  logic signed [9:0] w_e;
  logic [9:0]  w_neg_e;
  logic        w_special, w_nan, w_to_round;
  assign w_exp = operand[30:23];
  assign w_mant = operand[22:0];
  assign w_e = (w_exp == 8'd0) ? -10'sd126 : $signed({2'b00, w_exp}) - E_BIAS;
  assign w_neg_e = 10'(-w_e);
  assign w_special = (&w_exp) | (w_e >= 10'sd32);
  assign w_nan = (&w_exp) & (|w_mant);
  assign w_rcnt = (w_neg_e > 10'd33) ? 6'd33 : w_neg_e[5:0];
  assign w_init_cnt = w_e[9] ? w_rcnt : w_e[5:0];
  assign w_base_r = {31'b0, |w_exp, w_mant, 9'b0};
`ifdef FPU_F2I_FASTZERO_EN
  logic w_fz_g, w_fz_st;
  assign w_fz_g = (w_e == -10'sd1);
  assign w_fz_st = (w_e < -10'sd1) ? |operand[30:0] : w_fz_g & |w_mant;
  assign w_init_r = w_e[9] ? {32'b0, w_fz_g, 30'b0, w_fz_st} : w_base_r;
  assign w_to_round = w_e[9] | (w_e == 10'sd0);
`else
  assign w_init_r = w_base_r;
  assign w_to_round = (w_e == 10'sd0);
`endif
  assign w_k = (r_cnt < S) ? r_cnt : S;
  assign w_shl = r_r << w_k;
  // bits shifted out on the right collapse into a sticky LSB
  assign w_shr = (r_r >> w_k) | {63'b0, |(r_r & ~({64{1'b1}} << w_k))};
  fpu_f2i_round u_round (
    .i_r     (r_r),
    .i_sign  (r_sign),
    .i_rm    (r_rm),
    .i_uns   (r_uns),
    .o_result(w_rnd_res),
    .o_flags (w_rnd_flags)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      F2I_IDLE:  if (in_valid) w_next = w_special ? F2I_DONE : w_to_round ? F2I_ROUND : F2I_ALIGN;
      F2I_ALIGN: if (r_cnt == w_k) w_next = F2I_ROUND;
      F2I_ROUND: w_next = F2I_DONE;
      F2I_DONE:  if (out_ready) w_next = F2I_IDLE;
      default:   w_next = F2I_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= F2I_IDLE;
      r_r <= '0;
      r_cnt <= '0;
      r_left <= 1'b0;
      r_sign <= 1'b0;
      r_uns <= 1'b0;
      r_rm <= RM_RNE;
      r_res <= '0;
      r_nv <= 1'b0;
      r_nx <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        F2I_IDLE: if (in_valid) begin
          r_r <= w_init_r;
          r_cnt <= w_init_cnt;
          r_left <= ~w_e[9];
          r_sign <= operand[31];
          r_uns <= is_unsigned;
          r_rm <= rm;
          if (w_special) begin
            r_res <= f2i_sat(is_unsigned, operand[31] & ~w_nan);
            r_nv <= 1'b1;
            r_nx <= 1'b0;
          end
        end
        F2I_ALIGN: begin
          r_r <= r_left ? w_shl : w_shr;
          r_cnt <= r_cnt - w_k;
        end
        F2I_ROUND: begin
          r_res <= w_rnd_res;
          r_nv <= w_rnd_flags[FLAG_NV];
          r_nx <= w_rnd_flags[FLAG_NX];
        end
        default: ;
      endcase
    end
  end
  assign in_ready = (r_state == F2I_IDLE);
  assign out_valid = (r_state == F2I_DONE);
  assign result = r_res;
  assign flag_nv = r_nv;
  assign flag_nx = r_nx;
endmodule

// File: tb/tb_fpu_float_to_int.sv
// tb_fpu_float_to_int: scoreboard bench with a real-arithmetic reference model for fpu_float_to_int
module tb_fpu_float_to_int;
  localparam int S = 4;
  typedef struct {
    logic [31:0] res;
    logic        nv;
    logic        nx;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk, rst_n, in_valid, in_ready, is_unsigned, out_valid, out_ready, flag_nv, flag_nx;
  logic [31:0] operand, result;
  logic [2:0]  rm;
  exp_t        q[$];
  int          checks = 0, errors = 0, cyc = 0;
  bit          hold = 1;

  fpu_float_to_int #(.SHIFT_PER_CYCLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .operand(operand),
    .is_unsigned(is_unsigned), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_nv(flag_nv), .flag_nx(flag_nx)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] sat(input logic uns, input logic neg);
    return uns ? (neg ? 32'h0 : 32'hFFFF_FFFF) : (neg ? 32'h8000_0000 : 32'h7FFF_FFFF);
  endfunction

  function automatic int lat_of(input logic [31:0] op);
    int ex = int'(op[30:23]);
    int e = (ex == 0) ? -126 : ex - 127;
    if (ex == 255 || e >= 32) return 1;
    if (e >= 0) return 2 + (e + S - 1) / S;
`ifdef FPU_F2I_FASTZERO_EN
    return 2;
`else
    return 2 + (((-e > 33) ? 33 : -e) + S - 1) / S;
`endif
  endfunction

  function automatic exp_t model(input logic [31:0] op, input logic uns, input logic [2:0] r_m);
    exp_t m;
    real x, fl, r;
    int ex = int'(op[30:23]);
    m.lat = lat_of(op);
    m.acc = 0;
    if (ex == 255) begin
      m.nv = 1;
      m.nx = 0;
      m.res = sat(uns, op[31] && op[22:0] == 0);
      return m;
    end
    x = real'(int'({ex != 0, op[22:0]})) * (2.0 ** (((ex == 0) ? -126 : ex - 127) - 23));
    if (op[31]) x = -x;
    fl = $floor(x);
    case (r_m)
      3'd1: r = (x < 0.0) ? $ceil(x) : fl;
      3'd2: r = fl;
      3'd3: r = $ceil(x);
      3'd4: r = (x < 0.0) ? -$floor(0.5 - x) : $floor(x + 0.5);
      default: r = (x - fl > 0.5) ? fl + 1.0 : (x - fl < 0.5) ? fl :
                   ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
    endcase
    if (r < (uns ? 0.0 : -2147483648.0) || r > (uns ? 4294967295.0 : 2147483647.0)) begin
      m.nv = 1;
      m.nx = 0;
      m.res = sat(uns, op[31]);
    end else begin
      m.nv = 0;
      m.nx = (r != x);
      m.res = 32'(longint'(r));
    end
    return m;
  endfunction

  function automatic exp_t lit(input logic [31:0] op, input logic [31:0] res, input logic nv, input logic nx);
    exp_t m;
    m.res = res;
    m.nv = nv;
    m.nx = nx;
    m.lat = lat_of(op);
    m.acc = 0;
    return m;
  endfunction

  function automatic logic [31:0] rand_op();
    int c = $urandom_range(0, 9);
    logic [7:0] ex;
    logic [22:0] m = 23'($urandom);
    ex = (c == 0) ? 8'd0 : (c == 1) ? 8'd255 : (c <= 3) ? 8'($urandom_range(150, 160)) :
         8'($urandom_range(100, 158));
    if (c == 4) m = m & (23'h7F_FFFF << $urandom_range(0, 22));
    if (c == 5) m = '0;
    return {1'($urandom), ex, m};
  endfunction

  task automatic send(input logic [31:0] op, input logic uns, input logic [2:0] r_m, input bit push, input exp_t e);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 after %0d cycles", t);
      return;
    end
    operand = op;
    is_unsigned = uns;
    rm = r_m;
    in_valid = 1;
    e.acc = cyc + 1;
    if (push) q.push_back(e);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic dir(input logic [31:0] op, input logic uns, input logic [2:0] r_m,
                     input logic [31:0] res, input logic nv, input logic nx);
    send(op, uns, r_m, 1, lit(op, res, nv, nx));
  endtask

  task automatic rnd(input logic [31:0] op, input logic uns, input logic [2:0] r_m);
    send(op, uns, r_m, 1, model(op, uns, r_m));
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk);
      #1 out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  int first = -1;
  logic [33:0] held;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) first = -1;
      else if (out_valid) begin
        if (first < 0) begin
          first = cyc;
          held = {result, flag_nv, flag_nx};
        end else chk("hold_stable", {result, flag_nv, flag_nx}, held);
        chk("in_ready_done", in_ready, 0);
        if (out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", result);
          end else begin
            e = q.pop_front();
            chk("result", result, e.res);
            chk("flag_nv", flag_nv, e.nv);
            chk("flag_nx", flag_nx, e.nx);
            chk("latency", first - e.acc + 1, e.lat);
          end
          first = -1;
        end
      end
    end
  end

  initial begin
    exp_t d;
    rst_n = 0;
    in_valid = 0;
    operand = 0;
    is_unsigned = 0;
    rm = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_nv, flag_nx}, 0);
    rst_n = 1;
    hold = 0;
    dir(32'h40490FDB, 0, 3'd0, 32'h0000_0003, 0, 1);
    dir(32'hBFC00000, 0, 3'd0, 32'hFFFF_FFFE, 0, 1);
    dir(32'hBFC00000, 0, 3'd1, 32'hFFFF_FFFF, 0, 1);
    dir(32'hBFC00000, 0, 3'd4, 32'hFFFF_FFFE, 0, 1);
    dir(32'h4F000000, 0, 3'd0, 32'h7FFF_FFFF, 1, 0);
    dir(32'h4F000000, 1, 3'd0, 32'h8000_0000, 0, 0);
    dir(32'h7FC00000, 0, 3'd0, 32'h7FFF_FFFF, 1, 0);
    dir(32'hBF800000, 1, 3'd0, 32'h0000_0000, 1, 0);
    dir(32'hBE99999A, 1, 3'd1, 32'h0000_0000, 0, 1);
    dir(32'h3F000000, 0, 3'd0, 32'h0000_0000, 0, 1);
    dir(32'h3F000000, 0, 3'd3, 32'h0000_0001, 0, 1);
    dir(32'h80000001, 0, 3'd2, 32'hFFFF_FFFF, 0, 1);
    dir(32'h00000000, 0, 3'd0, 32'h0000_0000, 0, 0);
    dir(32'hCF000000, 0, 3'd0, 32'h8000_0000, 0, 0);
    dir(32'h4EFFFFFF, 0, 3'd0, 32'h7FFF_FF80, 0, 0);
    dir(32'h7F800000, 1, 3'd0, 32'hFFFF_FFFF, 1, 0);
    dir(32'hFF800000, 0, 3'd0, 32'h8000_0000, 1, 0);
    dir(32'h4F800000, 1, 3'd0, 32'hFFFF_FFFF, 1, 0);
    dir(32'h3FC00000, 0, 3'd7, 32'h0000_0002, 0, 1);
    drain();
    hold = 1;
    @(posedge clk);
    #2;
    dir(32'h40490FDB, 0, 3'd0, 32'h0000_0003, 0, 1);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    chk("stall_reached_done", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
    end
    hold = 0;
    drain();
    send(32'h4F7FFFFF, 0, 3'd0, 0, d);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midop_rst_out_valid", out_valid, 0);
    chk("midop_rst_in_ready", in_ready, 1);
    chk("midop_rst_result", result, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 300; i++) rnd(rand_op(), 1'($urandom), 3'($urandom_range(0, 7)));
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
